// File: rtl/scr1_dmem_port_router_pkg.sv
// Shared types and constants for the DMEM port router.
//
// Contents:
//   - DMEM bus widths.
//   - Default TCM and timer address windows.
//   - Memory interface enums: command, access width and response.
//   - Router-local enums: FSM state and target port encoding.
package scr1_dmem_port_router_pkg;

  localparam int unsigned SCR1_DMEM_AWIDTH = 32;
  localparam int unsigned SCR1_DMEM_DWIDTH = 32;

  // Default address windows (architecture description).
  localparam logic [SCR1_DMEM_AWIDTH-1:0] SCR1_TCM_ADDR_MASK      = 32'hFFFF0000;
  localparam logic [SCR1_DMEM_AWIDTH-1:0] SCR1_TCM_ADDR_PATTERN   = 32'h00480000;
  localparam logic [SCR1_DMEM_AWIDTH-1:0] SCR1_TIMER_ADDR_MASK    = 32'hFFFFFFE0;
  localparam logic [SCR1_DMEM_AWIDTH-1:0] SCR1_TIMER_ADDR_PATTERN = 32'h00490000;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  typedef enum logic {
    SCR1_FSM_ADDR = 1'b0,
    SCR1_FSM_DATA = 1'b1
  } type_scr1_dmem_rtr_fsm_e;

  typedef enum logic [1:0] {
    PORT_EXT = 2'b00,
    PORT_TCM = 2'b01,
    PORT_TMR = 2'b10
  } type_scr1_dmem_rtr_port_e;

endpackage

// File: rtl/scr1_dmem_port_router.sv
// DMEM port router: steers each pipeline data-memory request to the TCM,
// the memory-mapped timer or the external bus, and returns the response
// of the port that accepted the request. One outstanding transaction,
// back-to-back issue allowed on the response cycle; req/ack and resp/rdata
// are combinational pass-throughs.
//
// Ports:
//   clk, rst                 core clock, synchronous active-high reset
//   pipe2rtr_*               request from the pipeline (req/cmd/width/addr/wdata)
//   rtr2pipe_*               accept, read data and response to the pipeline
//   rtr2{tcm,tmr,ext}_*      request to each target (req qualified, rest shared)
//   {tcm,tmr,ext}2rtr_*      accept, read data and response from each target
module scr1_dmem_port_router
  import scr1_dmem_port_router_pkg::*;
#(
  parameter logic [SCR1_DMEM_AWIDTH-1:0] TCM_ADDR_MASK      = SCR1_TCM_ADDR_MASK,
  parameter logic [SCR1_DMEM_AWIDTH-1:0] TCM_ADDR_PATTERN   = SCR1_TCM_ADDR_PATTERN,
  parameter logic [SCR1_DMEM_AWIDTH-1:0] TIMER_ADDR_MASK    = SCR1_TIMER_ADDR_MASK,
  parameter logic [SCR1_DMEM_AWIDTH-1:0] TIMER_ADDR_PATTERN = SCR1_TIMER_ADDR_PATTERN
) (
  input  logic                        clk,
  input  logic                        rst,
  // pipeline side
  input  logic                        pipe2rtr_req_i,
  input  type_scr1_mem_cmd_e          pipe2rtr_cmd_i,
  input  type_scr1_mem_width_e        pipe2rtr_width_i,
  input  logic [SCR1_DMEM_AWIDTH-1:0] pipe2rtr_addr_i,
  input  logic [SCR1_DMEM_DWIDTH-1:0] pipe2rtr_wdata_i,
  output logic                        rtr2pipe_req_ack_o,
  output logic [SCR1_DMEM_DWIDTH-1:0] rtr2pipe_rdata_o,
  output type_scr1_mem_resp_e         rtr2pipe_resp_o,
  // TCM port
  output logic                        rtr2tcm_req_o,
  output type_scr1_mem_cmd_e          rtr2tcm_cmd_o,
  output type_scr1_mem_width_e        rtr2tcm_width_o,
  output logic [SCR1_DMEM_AWIDTH-1:0] rtr2tcm_addr_o,
  output logic [SCR1_DMEM_DWIDTH-1:0] rtr2tcm_wdata_o,
  input  logic                        tcm2rtr_req_ack_i,
  input  logic [SCR1_DMEM_DWIDTH-1:0] tcm2rtr_rdata_i,
  input  type_scr1_mem_resp_e         tcm2rtr_resp_i,
  // timer port
  output logic                        rtr2tmr_req_o,
  output type_scr1_mem_cmd_e          rtr2tmr_cmd_o,
  output type_scr1_mem_width_e        rtr2tmr_width_o,
  output logic [SCR1_DMEM_AWIDTH-1:0] rtr2tmr_addr_o,
  output logic [SCR1_DMEM_DWIDTH-1:0] rtr2tmr_wdata_o,
  input  logic                        tmr2rtr_req_ack_i,
  input  logic [SCR1_DMEM_DWIDTH-1:0] tmr2rtr_rdata_i,
  input  type_scr1_mem_resp_e         tmr2rtr_resp_i,
  // external bus port
  output logic                        rtr2ext_req_o,
  output type_scr1_mem_cmd_e          rtr2ext_cmd_o,
  output type_scr1_mem_width_e        rtr2ext_width_o,
  output logic [SCR1_DMEM_AWIDTH-1:0] rtr2ext_addr_o,
  output logic [SCR1_DMEM_DWIDTH-1:0] rtr2ext_wdata_o,
  input  logic                        ext2rtr_req_ack_i,
  input  logic [SCR1_DMEM_DWIDTH-1:0] ext2rtr_rdata_i,
  input  type_scr1_mem_resp_e         ext2rtr_resp_i
);

  localparam logic [0:0] FSM_ADDR = SCR1_FSM_ADDR;
  localparam logic [0:0] FSM_DATA = SCR1_FSM_DATA;

  // TCM is checked first so it wins if the two windows are ever configured
  // to overlap.
  function automatic type_scr1_dmem_rtr_port_e decode(input logic [SCR1_DMEM_AWIDTH-1:0] addr);
    if ((addr & TCM_ADDR_MASK) == TCM_ADDR_PATTERN) begin
      return PORT_TCM;
    end else if ((addr & TIMER_ADDR_MASK) == TIMER_ADDR_PATTERN) begin
      return PORT_TMR;
    end
    return PORT_EXT;
  endfunction

  logic [0:0]                  fsm;
  logic [0:0]                  fsm_next;
  type_scr1_dmem_rtr_port_e    port_sel;
  type_scr1_dmem_rtr_port_e    port_sel_next;
  type_scr1_dmem_rtr_port_e    sel_dec;
  logic                        dec_ack;
  type_scr1_mem_resp_e         sel_resp;
  logic [SCR1_DMEM_DWIDTH-1:0] sel_rdata;
  logic                        issue;

  // Accept from the port the current address decodes to.
  // NOTE: every variable written in an always_comb gets a default before any
  // branch; a path that leaves one unassigned would infer a latch.
  always_comb begin
    sel_dec = decode(pipe2rtr_addr_i);
    dec_ack = ext2rtr_req_ack_i;
    case (sel_dec)
      PORT_TCM: dec_ack = tcm2rtr_req_ack_i;
      PORT_TMR: dec_ack = tmr2rtr_req_ack_i;
      default:  dec_ack = ext2rtr_req_ack_i;
    endcase
  end

  // Response of the port that owns the outstanding transaction; the other
  // ports' responses never reach the pipeline.
  always_comb begin
    sel_resp  = ext2rtr_resp_i;
    sel_rdata = ext2rtr_rdata_i;
    case (port_sel)
      PORT_TCM: begin
        sel_resp  = tcm2rtr_resp_i;
        sel_rdata = tcm2rtr_rdata_i;
      end
      PORT_TMR: begin
        sel_resp  = tmr2rtr_resp_i;
        sel_rdata = tmr2rtr_rdata_i;
      end
      default: begin
        sel_resp  = ext2rtr_resp_i;
        sel_rdata = ext2rtr_rdata_i;
      end
    endcase
  end

  // issue: a new request may be forwarded this cycle. That is always true
  // when idle, and in DATA only on an OK response (an error response drains
  // the pipeline for one cycle before anything new is sent).
  always_comb begin
    issue            = 1'b0;
    rtr2pipe_resp_o  = SCR1_MEM_RESP_NOTRDY;
    rtr2pipe_rdata_o = '0;
    fsm_next         = fsm;
    port_sel_next    = port_sel;

    if (fsm == FSM_DATA) begin
      rtr2pipe_resp_o  = sel_resp;
      rtr2pipe_rdata_o = sel_rdata;
      issue            = (sel_resp == SCR1_MEM_RESP_RDY_OK);
      if (sel_resp != SCR1_MEM_RESP_NOTRDY) begin
        fsm_next = FSM_ADDR;
      end
    end else begin
      issue = 1'b1;
    end

    if (issue && pipe2rtr_req_i && dec_ack) begin
      fsm_next      = FSM_DATA;
      port_sel_next = sel_dec;
    end

    // While reset is held nothing is accepted or reported, so a transaction
    // cut off by reset cannot leak a response or a handshake.
    if (rst) begin
      issue            = 1'b0;
      rtr2pipe_resp_o  = SCR1_MEM_RESP_NOTRDY;
      rtr2pipe_rdata_o = '0;
    end
  end

  assign rtr2pipe_req_ack_o = issue & dec_ack;

  assign rtr2tcm_req_o = issue & pipe2rtr_req_i & (sel_dec == PORT_TCM);
  assign rtr2tmr_req_o = issue & pipe2rtr_req_i & (sel_dec == PORT_TMR);
  assign rtr2ext_req_o = issue & pipe2rtr_req_i & (sel_dec == PORT_EXT);

  // Request fields are broadcast; only req selects the target.
  assign rtr2tcm_cmd_o   = pipe2rtr_cmd_i;
  assign rtr2tcm_width_o = pipe2rtr_width_i;
  assign rtr2tcm_addr_o  = pipe2rtr_addr_i;
  assign rtr2tcm_wdata_o = pipe2rtr_wdata_i;
  assign rtr2tmr_cmd_o   = pipe2rtr_cmd_i;
  assign rtr2tmr_width_o = pipe2rtr_width_i;
  assign rtr2tmr_addr_o  = pipe2rtr_addr_i;
  assign rtr2tmr_wdata_o = pipe2rtr_wdata_i;
  assign rtr2ext_cmd_o   = pipe2rtr_cmd_i;
  assign rtr2ext_width_o = pipe2rtr_width_i;
  assign rtr2ext_addr_o  = pipe2rtr_addr_i;
  assign rtr2ext_wdata_o = pipe2rtr_wdata_i;

  // NOTE: state registers use non-blocking assignments so every flop
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm      <= FSM_ADDR;
      port_sel <= PORT_EXT;
    end else begin
      fsm      <= fsm_next;
      port_sel <= port_sel_next;
    end
  end

`ifndef SYNTHESIS
  a_single_port_req : assert property (@(posedge clk) disable iff (rst)
    $onehot0({rtr2tcm_req_o, rtr2tmr_req_o, rtr2ext_req_o}));
`endif

endmodule

// File: tb/tb_scr1_dmem_port_router.sv
// Self-checking bench for scr1_dmem_port_router. Target ports are driven
// directly per cycle; expected pipeline responses are queued when the
// matching request is accepted and popped by a monitor whenever the router
// reports a non-idle response.
module tb_scr1_dmem_port_router;
  import scr1_dmem_port_router_pkg::*;

  typedef struct packed {
    type_scr1_mem_resp_e resp;
    logic [31:0]         rdata;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 req;
  type_scr1_mem_cmd_e   cmd;
  type_scr1_mem_width_e width;
  logic [31:0]          addr;
  logic [31:0]          wdata;
  logic                 ack;
  logic [31:0]          rdata;
  type_scr1_mem_resp_e  resp;

  logic tcm_req, tmr_req, ext_req;
  type_scr1_mem_cmd_e   tcm_cmd, tmr_cmd, ext_cmd;
  type_scr1_mem_width_e tcm_width, tmr_width, ext_width;
  logic [31:0] tcm_addr, tmr_addr, ext_addr;
  logic [31:0] tcm_wdata, tmr_wdata, ext_wdata;
  logic tcm_ack, tmr_ack, ext_ack;
  logic [31:0] tcm_rdata, tmr_rdata, ext_rdata;
  type_scr1_mem_resp_e tcm_resp, tmr_resp, ext_resp;

  logic [2:0] reqs;
  assign reqs = {tcm_req, tmr_req, ext_req};

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  scr1_dmem_port_router dut (
    .clk                (clk),
    .rst                (rst),
    .pipe2rtr_req_i     (req),
    .pipe2rtr_cmd_i     (cmd),
    .pipe2rtr_width_i   (width),
    .pipe2rtr_addr_i    (addr),
    .pipe2rtr_wdata_i   (wdata),
    .rtr2pipe_req_ack_o (ack),
    .rtr2pipe_rdata_o   (rdata),
    .rtr2pipe_resp_o    (resp),
    .rtr2tcm_req_o      (tcm_req),
    .rtr2tcm_cmd_o      (tcm_cmd),
    .rtr2tcm_width_o    (tcm_width),
    .rtr2tcm_addr_o     (tcm_addr),
    .rtr2tcm_wdata_o    (tcm_wdata),
    .tcm2rtr_req_ack_i  (tcm_ack),
    .tcm2rtr_rdata_i    (tcm_rdata),
    .tcm2rtr_resp_i     (tcm_resp),
    .rtr2tmr_req_o      (tmr_req),
    .rtr2tmr_cmd_o      (tmr_cmd),
    .rtr2tmr_width_o    (tmr_width),
    .rtr2tmr_addr_o     (tmr_addr),
    .rtr2tmr_wdata_o    (tmr_wdata),
    .tmr2rtr_req_ack_i  (tmr_ack),
    .tmr2rtr_rdata_i    (tmr_rdata),
    .tmr2rtr_resp_i     (tmr_resp),
    .rtr2ext_req_o      (ext_req),
    .rtr2ext_cmd_o      (ext_cmd),
    .rtr2ext_width_o    (ext_width),
    .rtr2ext_addr_o     (ext_addr),
    .rtr2ext_wdata_o    (ext_wdata),
    .ext2rtr_req_ack_i  (ext_ack),
    .ext2rtr_rdata_i    (ext_rdata),
    .ext2rtr_resp_i     (ext_resp)
  );

  // Scoreboard monitor: any non-idle pipeline response must match the
  // oldest expected entry.
  always @(negedge clk) begin
    if (resp !== SCR1_MEM_RESP_NOTRDY) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got resp=%0d rdata=%h, required no response", resp, rdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({resp, rdata} !== {e.resp, e.rdata}) begin
          n_err++;
          $display("FAIL sb_resp: got resp=%0d rdata=%h, required resp=%0d rdata=%h",
                   resp, rdata, e.resp, e.rdata);
        end
      end
    end
  end

  // Inputs change 1 time unit after the rising edge; outputs are observed
  // on the falling edge.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic obs();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req = 1'b0; cmd = SCR1_MEM_CMD_RD; width = SCR1_MEM_WIDTH_WORD;
    addr = '0; wdata = '0;
    tcm_ack = 1'b0; tmr_ack = 1'b0; ext_ack = 1'b0;
    tcm_rdata = '0; tmr_rdata = '0; ext_rdata = '0;
    tcm_resp = SCR1_MEM_RESP_NOTRDY; tmr_resp = SCR1_MEM_RESP_NOTRDY;
    ext_resp = SCR1_MEM_RESP_NOTRDY;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    next_cyc();
    obs();
    n_cmp++;
    if ({reqs, ack} !== 4'b0000) begin
      n_err++; $display("FAIL reset_req_ack: got reqs=%b ack=%b, required 000/0", reqs, ack);
    end
    n_cmp++;
    if (resp !== SCR1_MEM_RESP_NOTRDY || rdata !== 32'h0) begin
      n_err++; $display("FAIL reset_resp: got resp=%0d rdata=%h, required 0/0", resp, rdata);
    end
    next_cyc();
    rst = 1'b0;
    obs();
    n_cmp++;
    if ({reqs, ack, resp} !== 6'b0000_00) begin
      n_err++; $display("FAIL reset_release: got reqs=%b ack=%b resp=%0d, required idle", reqs, ack, resp);
    end
    next_cyc();
  endtask

  task automatic test_decode();
    logic [31:0] a_tab[8] = '{32'h00480000, 32'h0048FFFF, 32'h00490000, 32'h0049001F,
                              32'h00490020, 32'h0047FFFF, 32'h20000000, 32'h00491000};
    logic [2:0]  r_tab[8] = '{3'b100, 3'b100, 3'b010, 3'b010,
                              3'b001, 3'b001, 3'b001, 3'b001};
    for (int i = 0; i < 8; i++) begin
      req = 1'b1; addr = a_tab[i];
      obs();
      n_cmp++;
      if (reqs !== r_tab[i] || ack !== 1'b0) begin
        n_err++;
        $display("FAIL decode_%0d: addr=%h got reqs=%b ack=%b, required reqs=%b ack=0",
                 i, a_tab[i], reqs, ack, r_tab[i]);
      end
      next_cyc();
    end
    idle_inputs();
    next_cyc();
  endtask

  task automatic test_tcm_read();
    req = 1'b1; cmd = SCR1_MEM_CMD_RD; addr = 32'h00480010; tcm_ack = 1'b1;
    obs();
    n_cmp++;
    if (reqs !== 3'b100 || ack !== 1'b1) begin
      n_err++; $display("FAIL tcm_read_issue: got reqs=%b ack=%b, required 100/1", reqs, ack);
    end
    n_cmp++;
    if (ext_addr !== 32'h00480010 || tmr_cmd !== SCR1_MEM_CMD_RD) begin
      n_err++; $display("FAIL tcm_read_broadcast: got ext_addr=%h tmr_cmd=%0d, required 00480010/0", ext_addr, tmr_cmd);
    end
    exp_q.push_back('{SCR1_MEM_RESP_RDY_OK, 32'hDEADBEEF});
    next_cyc();
    idle_inputs();
    tcm_resp = SCR1_MEM_RESP_RDY_OK; tcm_rdata = 32'hDEADBEEF;
    obs();
    n_cmp++;
    if (resp !== SCR1_MEM_RESP_RDY_OK || reqs !== 3'b000) begin
      n_err++; $display("FAIL tcm_read_resp: got resp=%0d reqs=%b, required 1/000", resp, reqs);
    end
    next_cyc();
    // Router back in ADDR: a lingering TCM response must not be forwarded.
    tcm_rdata = 32'h12345678;
    obs();
    n_cmp++;
    if (resp !== SCR1_MEM_RESP_NOTRDY || rdata !== 32'h0) begin
      n_err++; $display("FAIL tcm_read_back_to_addr: got resp=%0d rdata=%h, required 0/0", resp, rdata);
    end
    idle_inputs();
    next_cyc();
  endtask

  task automatic test_timer_write_wait();
    req = 1'b1; cmd = SCR1_MEM_CMD_WR; addr = 32'h00490008; wdata = 32'hCAFEF00D;
    for (int i = 0; i < 3; i++) begin
      obs();
      n_cmp++;
      if (reqs !== 3'b010 || ack !== 1'b0 || tmr_wdata !== 32'hCAFEF00D) begin
        n_err++;
        $display("FAIL tmr_wait_%0d: got reqs=%b ack=%b wdata=%h, required 010/0/cafef00d",
                 i, reqs, ack, tmr_wdata);
      end
      next_cyc();
    end
    tmr_ack = 1'b1;
    obs();
    n_cmp++;
    if (reqs !== 3'b010 || ack !== 1'b1) begin
      n_err++; $display("FAIL tmr_accept: got reqs=%b ack=%b, required 010/1", reqs, ack);
    end
    exp_q.push_back('{SCR1_MEM_RESP_RDY_OK, 32'h0});
    next_cyc();
    idle_inputs();
    obs();
    n_cmp++;
    if (resp !== SCR1_MEM_RESP_NOTRDY) begin
      n_err++; $display("FAIL tmr_pending: got resp=%0d, required 0", resp);
    end
    next_cyc();
    tmr_resp = SCR1_MEM_RESP_RDY_OK;
    obs();
    n_cmp++;
    if (resp !== SCR1_MEM_RESP_RDY_OK) begin
      n_err++; $display("FAIL tmr_resp: got resp=%0d, required 1", resp);
    end
    next_cyc();
    idle_inputs();
    next_cyc();
  endtask

  task automatic test_back_to_back();
    req = 1'b1; addr = 32'h00480020; tcm_ack = 1'b1;
    obs();
    exp_q.push_back('{SCR1_MEM_RESP_RDY_OK, 32'h11111111});
    next_cyc();
    tcm_ack = 1'b0; tcm_resp = SCR1_MEM_RESP_RDY_OK; tcm_rdata = 32'h11111111;
    req = 1'b1; addr = 32'h20000000; ext_ack = 1'b1;
    obs();
    n_cmp++;
    if (reqs !== 3'b001 || ack !== 1'b1 || resp !== SCR1_MEM_RESP_RDY_OK) begin
      n_err++; $display("FAIL b2b_issue: got reqs=%b ack=%b resp=%0d, required 001/1/1", reqs, ack, resp);
    end
    exp_q.push_back('{SCR1_MEM_RESP_RDY_OK, 32'h22222222});
    next_cyc();
    // Still in DATA on EXT: the TCM response left on the bus is ignored.
    req = 1'b0; ext_ack = 1'b0; tcm_rdata = 32'h33333333;
    obs();
    n_cmp++;
    if (resp !== SCR1_MEM_RESP_NOTRDY || reqs !== 3'b000) begin
      n_err++; $display("FAIL b2b_hold: got resp=%0d reqs=%b, required 0/000", resp, reqs);
    end
    next_cyc();
    tcm_resp = SCR1_MEM_RESP_NOTRDY;
    ext_resp = SCR1_MEM_RESP_RDY_OK; ext_rdata = 32'h22222222;
    obs();
    n_cmp++;
    if (resp !== SCR1_MEM_RESP_RDY_OK) begin
      n_err++; $display("FAIL b2b_ext_resp: got resp=%0d, required 1", resp);
    end
    next_cyc();
    idle_inputs();
    next_cyc();
  endtask

  task automatic test_error();
    req = 1'b1; addr = 32'h20000004; ext_ack = 1'b1;
    obs();
    exp_q.push_back('{SCR1_MEM_RESP_RDY_ER, 32'hBAD0BAD0});
    next_cyc();
    ext_resp = SCR1_MEM_RESP_RDY_ER; ext_rdata = 32'hBAD0BAD0;
    req = 1'b1; addr = 32'h00480000; tcm_ack = 1'b1;
    obs();
    n_cmp++;
    if (reqs !== 3'b000 || ack !== 1'b0 || resp !== SCR1_MEM_RESP_RDY_ER) begin
      n_err++; $display("FAIL err_drain: got reqs=%b ack=%b resp=%0d, required 000/0/2", reqs, ack, resp);
    end
    next_cyc();
    ext_resp = SCR1_MEM_RESP_NOTRDY; ext_ack = 1'b0; ext_rdata = '0;
    obs();
    n_cmp++;
    if (reqs !== 3'b100 || ack !== 1'b1) begin
      n_err++; $display("FAIL err_reissue: got reqs=%b ack=%b, required 100/1", reqs, ack);
    end
    exp_q.push_back('{SCR1_MEM_RESP_RDY_OK, 32'h44444444});
    next_cyc();
    idle_inputs();
    tcm_resp = SCR1_MEM_RESP_RDY_OK; tcm_rdata = 32'h44444444;
    obs();
    next_cyc();
    idle_inputs();
    next_cyc();
  endtask

  task automatic test_spurious();
    req = 1'b1; addr = 32'h80000000; ext_ack = 1'b1;
    obs();
    exp_q.push_back('{SCR1_MEM_RESP_RDY_OK, 32'h00000055});
    next_cyc();
    idle_inputs();
    tcm_resp = SCR1_MEM_RESP_RDY_OK; tcm_rdata = 32'h00000066;
    tmr_resp = SCR1_MEM_RESP_RDY_ER;
    for (int i = 0; i < 2; i++) begin
      obs();
      n_cmp++;
      if (resp !== SCR1_MEM_RESP_NOTRDY) begin
        n_err++; $display("FAIL spurious_%0d: got resp=%0d, required 0", i, resp);
      end
      next_cyc();
    end
    ext_resp = SCR1_MEM_RESP_RDY_OK; ext_rdata = 32'h00000055;
    obs();
    n_cmp++;
    if (rdata !== 32'h00000055) begin
      n_err++; $display("FAIL spurious_ext_rdata: got %h, required 00000055", rdata);
    end
    next_cyc();
    idle_inputs();
    next_cyc();
  endtask

  task automatic test_reset_mid();
    req = 1'b1; addr = 32'h00480004; tcm_ack = 1'b1;
    obs();
    next_cyc();
    idle_inputs();
    rst = 1'b1;
    obs();
    n_cmp++;
    if (resp !== SCR1_MEM_RESP_NOTRDY || reqs !== 3'b000) begin
      n_err++; $display("FAIL rst_mid_hold: got resp=%0d reqs=%b, required 0/000", resp, reqs);
    end
    next_cyc();
    rst = 1'b0;
    tcm_resp = SCR1_MEM_RESP_RDY_OK; tcm_rdata = 32'h00000077;
    obs();
    n_cmp++;
    if (resp !== SCR1_MEM_RESP_NOTRDY || rdata !== 32'h0 || reqs !== 3'b000) begin
      n_err++; $display("FAIL rst_mid_late_resp: got resp=%0d rdata=%h reqs=%b, required 0/0/000", resp, rdata, reqs);
    end
    next_cyc();
    idle_inputs();
    next_cyc();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_tcm_read();
    test_timer_write_wait();
    test_back_to_back();
    test_error();
    test_spurious();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL sb_drain: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
